// File: rtl/up_down_count_n.sv
// Modulo-N synchronous up/down counter with parallel load, cascade terminal count,
// boundary pulse and sticky overflow flag; boundaries either wrap or saturate.
module up_down_count_n #(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter bit     SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [63:0]      MOD_64  = 64'(MODULUS);

    // Compare in a 64-bit domain so MODULUS = 2**32 needs no special case.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        if (64'(v) >= MOD_64) begin
            return MAX_VAL;
        end
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] boundary_next(input logic [WIDTH-1:0] cur,
                                                       input logic           dir);
        if (SATURATE) begin
            return cur;
        end
        return dir ? '0 : MAX_VAL;
    endfunction

    logic at_max;
    logic at_min;

    assign at_max = (q == MAX_VAL);
    assign at_min = (q == '0);

    // Not gated by load: downstream stages qualify it with their own load.
    assign tc = en & ((up & at_max) | (~up & at_min));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else if (load) begin
            q    <= clamp_load(d);
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else if (en) begin
            if (tc) begin
                q    <= boundary_next(q, up);
                wrap <= 1'b1;
                ovf  <= 1'b1;
            end else begin
                q    <= up ? q + WIDTH'(1) : q - WIDTH'(1);
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule
